// File: rtl/wb_uart_rx.sv
// Wishbone UART receiver: 8N1 deserialiser feeding a byte FIFO popped via the DATA register.
// Optional define UART_RX_GLITCH_FILTER_EN selects 2-of-3 majority bit sampling.
module wb_uart_rx #(
   parameter int DIV   = 868,
   parameter int CW    = $clog2(DIV),
   parameter int DEPTH = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic [1:0]  adr_i,
   input  logic        we_i,
   input  logic [31:0] dat_i,
   input  logic [3:0]  sel_i,
   output logic        ack_o,
   output logic [31:0] dat_o,
   input  logic        rxd
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   logic rxd_meta_q, rxd_s_q, bit_s;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

`ifdef UART_RX_GLITCH_FILTER_EN
   logic [2:0] hist_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) hist_q <= '1;
      else       hist_q <= {hist_q[1:0], rxd_s_q};
   end

   always_comb begin
      bit_s = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
   end
`else
   always_comb begin
      bit_s = rxd_s_q;
   end
`endif

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      idx_q;
   logic [7:0]      shift_q;
   logic            at_end, push_d, ferr_set_d;

   always_comb begin
      at_end     = (cnt_q == CNT_LAST);
      push_d     = (state_q == S_STOP) && at_end && bit_s;
      ferr_set_d = (state_q == S_STOP) && at_end && !bit_s;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_WAIT_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         case (state_q)
            S_WAIT_IDLE: begin
               if (!rxd_s_q) cnt_q <= '0;
               else if (at_end) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else cnt_q <= cnt_q + CW'(1);
            end
            S_IDLE: begin
               cnt_q <= '0;
               if (!rxd_s_q) state_q <= S_START;
            end
            S_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  state_q <= bit_s ? S_IDLE : S_DATA;
               end else cnt_q <= cnt_q + CW'(1);
            end
            S_DATA: begin
               if (at_end) begin
                  cnt_q   <= '0;
                  shift_q <= {bit_s, shift_q[7:1]};
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= S_STOP;
               end else cnt_q <= cnt_q + CW'(1);
            end
            S_STOP: begin
               if (at_end) begin
                  cnt_q   <= '0;
                  state_q <= bit_s ? S_IDLE : S_WAIT_IDLE;
               end else cnt_q <= cnt_q + CW'(1);
            end
            default: begin
               state_q <= S_WAIT_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_q, rd_q, fill;
   logic        ack_q, ovf_q, ferr_q;
   logic [31:0] dat_q, rdata, status;
   logic [7:0]  fill8;
   logic        empty, full, req, pop, wr_en, ovf_set, clr, ovf_d, ferr_d;
   logic        unused_ok;

   always_comb begin
      fill    = wr_q - rd_q;
      empty   = (fill == '0);
      full    = (fill == (AW+1)'(DEPTH));
      req     = cyc_i & stb_i & ~ack_q;
      pop     = req & ~we_i & (adr_i == 2'd0) & ~empty;
      // a pop in the same cycle frees the slot, so a push on full still lands
      wr_en   = push_d & (~full | pop);
      ovf_set = push_d & full & ~pop;
      clr     = req & we_i & (adr_i == 2'd1) & sel_i[0];
      ovf_d   = ovf_set    | (ovf_q  & ~(clr & dat_i[2]));
      ferr_d  = ferr_set_d | (ferr_q & ~(clr & dat_i[3]));
      fill8   = (32'(fill) > 32'd255) ? 8'hFF : 8'(fill);
      status  = {16'h0, fill8, 4'h0, ferr_q, ovf_q, full, ~empty};
      rdata   = '0;
      if (!we_i) begin
         case (adr_i)
            2'd0:    rdata = empty ? '0 : {mem_q[rd_q[AW-1:0]], 24'h0};
            2'd1:    rdata = status;
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_q  <= 1'b0;
         dat_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         ovf_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ack_q  <= req;
         if (req)   dat_q <= rdata;
         if (wr_en) wr_q  <= wr_q + (AW+1)'(1);
         if (pop)   rd_q  <= rd_q + (AW+1)'(1);
         ovf_q  <= ovf_d;
         ferr_q <= ferr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= shift_q;
   end

   assign ack_o     = ack_q;
   assign dat_o     = dat_q;
   assign unused_ok = ^{dat_i[31:4], dat_i[1:0], sel_i[3:1]};

endmodule
